uart_cmd_sequencer: RTL

Command sequencer between the UART RX/TX FIFOs and the 0–9999 counter core. It pops received ASCII bytes from the RX FIFO and decodes run/stop/clear/query commands into single-cycle control pulses for the counter. It also owns the TX FIFO write port, and is the only writer to it. On that port it time-shares two sources: per-byte echo, and a six-byte decimal status report of the counter value.

---
 rtl/uart_cmd_sequencer_if.sv | 31 +++
 rtl/uart_cmd_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if
// Bundles the RX and TX FIFO ports that the command sequencer works against.
//   rx_empty  RX FIFO empty flag
//   rx_rdata  RX FIFO head byte, first-word fall-through
//   rx_pop    RX FIFO read strobe, one pulse consumes the head byte
//   tx_full   TX FIFO full flag
//   tx_wdata  byte written into the TX FIFO
//   tx_push   TX FIFO write strobe
// Modports: master = sequencer side, slave = FIFO side.
//
// Handshake rules: rx_pop may only be high while rx_empty=0, and the head
// byte is consumed at the clock edge that ends that cycle. tx_push may only
// be high while tx_full=0, and tx_wdata is written at that same edge.
interface uart_cmd_sequencer_if;
    logic       rx_empty;
    logic [7:0] rx_rdata;
    logic       rx_pop;
    logic       tx_full;
    logic [7:0] tx_wdata;
    logic       tx_push;

    modport master (
        input  rx_empty, rx_rdata, tx_full,
        output rx_pop, tx_wdata, tx_push
    );

    modport slave (
        output rx_empty, rx_rdata, tx_full,
        input  rx_pop, tx_wdata, tx_push
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
// Pops ASCII command bytes from the RX FIFO, turns R/S/C (either case) into
// one-cycle run/stop/clear pulses for the counter, echoes non-query bytes
// and answers Q with a six-byte decimal report "DDDD\r\n" of the counter.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   fifo        RX/TX FIFO port bundle (master side)
//   cnt_bcd     counter value, four BCD digits, [15:12] = thousands
//   cmd_run     one-cycle start pulse
//   cmd_stop    one-cycle stop pulse
//   cmd_clear   one-cycle clear pulse
//   busy        high whenever the FSM is not idle
//   state_o     current FSM state, for observation
module uart_cmd_sequencer #(
    parameter bit ECHO_EN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_cmd_sequencer_if.master          fifo,
    input  logic [15:0]                   cnt_bcd,
    output logic                          cmd_run,
    output logic                          cmd_stop,
    output logic                          cmd_clear,
    output logic                          busy,
    output logic [1:0]                    state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ECHO   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] snap_q, snap_d;
    logic [2:0]  idx_q, idx_d;

    logic        rx_pop;
    logic        tx_push;
    logic [7:0]  tx_wdata;
    logic [7:0]  cmd_lc;
    logic [7:0]  report_byte;
    logic [3:0]  nibble;

    // Setting bit 5 folds upper-case letters onto lower case; no other byte
    // lands on r/s/c/q this way.
    assign cmd_lc = cmd_q | 8'h20;

    always_comb begin
        nibble = 4'h0;
        report_byte = 8'h00;
        case (idx_q)
            3'd0:    nibble = snap_q[15:12];
            3'd1:    nibble = snap_q[11:8];
            3'd2:    nibble = snap_q[7:4];
            3'd3:    nibble = snap_q[3:0];
            default: nibble = 4'h0;
        endcase
        case (idx_q)
            3'd4:    report_byte = 8'h0D;
            3'd5:    report_byte = 8'h0A;
            default: report_byte = 8'h30 + {4'h0, nibble};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= 8'h00;
            snap_q  <= 16'h0000;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        rx_pop    = 1'b0;
        tx_push   = 1'b0;
        tx_wdata  = 8'h00;
        cmd_run   = 1'b0;
        cmd_stop  = 1'b0;
        cmd_clear = 1'b0;
        case (state_q)
            IDLE: begin
                // rst gates the pop so every output reads 0 while reset is held.
                if (!fifo.rx_empty && !rst) begin
                    rx_pop  = 1'b1;
                    cmd_d   = fifo.rx_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (cmd_lc)
                    8'h72:   cmd_run   = 1'b1;
                    8'h73:   cmd_stop  = 1'b1;
                    8'h63:   cmd_clear = 1'b1;
                    default: ;
                endcase
                if (cmd_lc == 8'h71) begin
                    // Freeze the counter value so the report is self-consistent.
                    snap_d  = cnt_bcd;
                    idx_d   = 3'd0;
                    state_d = REPORT;
                end else begin
                    state_d = ECHO_EN ? ECHO : IDLE;
                end
            end
            ECHO: begin
                tx_wdata = cmd_q;
                if (!fifo.tx_full) begin
                    tx_push = 1'b1;
                    state_d = IDLE;
                end
            end
            REPORT: begin
                tx_wdata = report_byte;
                if (!fifo.tx_full) begin
                    tx_push = 1'b1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd5) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo.rx_pop   = rx_pop;
    assign fifo.tx_push  = tx_push;
    assign fifo.tx_wdata = tx_wdata;
    assign busy          = (state_q != IDLE);
    assign state_o       = state_q;

endmodule
